// File: rtl/control_multi_if.sv
// Bundle of control, configuration and strobe signals for control_multi.
// The master drives enable and config; the slave returns strobes and count.
interface control_multi_if #(
    parameter int NB_COUNT = 2,
    parameter int N_CH     = 2
);
    logic                     i_enable;
    logic                     i_cfg_valid;
    logic [NB_COUNT-1:0]      i_period;
    logic [N_CH*NB_COUNT-1:0] i_offset;
    logic [N_CH-1:0]          o_valid;
    logic                     o_wrap;
    logic                     o_cfg_ack;
    logic [NB_COUNT-1:0]      o_count;

    modport master (
        output i_enable,
        output i_cfg_valid,
        output i_period,
        output i_offset,
        input  o_valid,
        input  o_wrap,
        input  o_cfg_ack,
        input  o_count
    );

    modport slave (
        input  i_enable,
        input  i_cfg_valid,
        input  i_period,
        input  i_offset,
        output o_valid,
        output o_wrap,
        output o_cfg_ack,
        output o_count
    );
endinterface

// File: rtl/control_multi.sv
// Multi-channel strobe generator: modulo counter with per-channel phase
// offsets; period/offsets shadowed and swapped only at a period boundary.
module control_multi #(
    parameter int NB_COUNT = 2,
    parameter int N_CH     = 2
) (
    input  logic            clock,
    input  logic            i_reset,
    control_multi_if.slave  bus
);
    localparam int NB_OFF = N_CH * NB_COUNT;

    logic [NB_COUNT-1:0] cnt;
    logic [NB_COUNT-1:0] per_act;
    logic [NB_COUNT-1:0] per_sh;
    logic [NB_OFF-1:0]   off_act;
    logic [NB_OFF-1:0]   off_sh;
    logic                pend;

    logic [N_CH-1:0]     valid_q;
    logic                wrap_q;
    logic                ack_q;

    logic                at_end;
    logic                apply_run;
    logic                apply_hold;
    logic [NB_COUNT-1:0] per_src;
    logic [NB_OFF-1:0]   off_src;

    // A request arriving in the apply cycle bypasses the shadow
    always_comb begin
        at_end     = (cnt == per_act);
        apply_run  = bus.i_enable && at_end
                     && (pend || bus.i_cfg_valid);
        apply_hold = !bus.i_enable && pend;
        per_src    = bus.i_cfg_valid ? bus.i_period : per_sh;
        off_src    = bus.i_cfg_valid ? bus.i_offset : off_sh;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt     <= '0;
            per_act <= '1;
            per_sh  <= '1;
            off_act <= '0;
            off_sh  <= '0;
            pend    <= 1'b0;
            valid_q <= '0;
            wrap_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            wrap_q <= bus.i_enable && at_end;
            ack_q  <= apply_run || apply_hold;
            for (int k = 0; k < N_CH; k++) begin
                valid_q[k] <= bus.i_enable
                    && (cnt == off_act[k*NB_COUNT +: NB_COUNT]);
            end

            if (bus.i_cfg_valid) begin
                per_sh <= bus.i_period;
                off_sh <= bus.i_offset;
                pend   <= 1'b1;
            end

            if (apply_run || apply_hold) begin
                per_act <= per_src;
                off_act <= off_src;
                pend    <= 1'b0;
            end

            // Paused reload restarts the period from zero
            if (apply_hold) begin
                cnt <= '0;
            end else if (bus.i_enable) begin
                cnt <= at_end ? '0 : cnt + 1'b1;
            end
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_wrap    = wrap_q;
    assign bus.o_cfg_ack = ack_q;
    assign bus.o_count   = cnt;
endmodule

// File: tb/tb_control_multi.sv
// Directed bench for control_multi (NB_COUNT=2, N_CH=2).
// Observed vector layout: {o_count[1:0], o_valid[1:0], o_wrap, o_cfg_ack}.
module tb_control_multi;
    logic clock = 1'b0;
    logic i_reset;
    int   n_pass = 0;
    int   n_tot  = 0;

    control_multi_if #(.NB_COUNT(2), .N_CH(2)) bus ();

    control_multi #(.NB_COUNT(2), .N_CH(2)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {bus.o_count, bus.o_valid, bus.o_wrap, bus.o_cfg_ack};
    endfunction

    task automatic test_reset();
        logic [5:0] got;
        i_reset         = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_cfg_valid = 1'b0;
        bus.i_period    = '0;
        bus.i_offset    = '0;
        tick();
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b00_00_0_0)
            $display("FAIL reset: got %b want %b", got, 6'b0);
        else n_pass++;
    endtask

    task automatic test_defaults();
        logic [5:0] got, exp;
        i_reset      = 1'b0;
        bus.i_enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            got = obs();
            exp = {2'(i % 4), (i % 4 == 1) ? 2'b11 : 2'b00,
                   (i % 4 == 0), 1'b0};
            n_tot++;
            if (got !== exp)
                $display("FAIL defaults[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_offsets();
        logic [5:0] got, exp;
        int waited;
        bus.i_cfg_valid = 1'b1;
        bus.i_period    = 2'd3;
        bus.i_offset    = {2'd2, 2'd0};
        tick();
        bus.i_cfg_valid = 1'b0;
        waited = 1;
        while (!bus.o_cfg_ack && waited < 8) begin
            tick();
            waited++;
        end
        n_tot++;
        if (!bus.o_cfg_ack || waited != 4 || bus.o_count != 2'd0)
            $display("FAIL offsets_ack: ack=%b wait=%0d cnt=%0d want 1/4/0",
                     bus.o_cfg_ack, waited, bus.o_count);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            got = obs();
            exp = {2'(i % 4),
                   (i % 4 == 1) ? 2'b01 : (i % 4 == 3) ? 2'b10 : 2'b00,
                   (i % 4 == 0), 1'b0};
            n_tot++;
            if (got !== exp)
                $display("FAIL offsets[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reload();
        logic [5:0] got, exp;
        logic [5:0] pre [3] = '{6'b10_00_0_0, 6'b11_10_0_0, 6'b00_00_1_1};
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b01_01_0_0)
            $display("FAIL mid_start: got %b want %b", got, 6'b01_01_0_0);
        else n_pass++;
        bus.i_cfg_valid = 1'b1;
        bus.i_period    = 2'd1;
        bus.i_offset    = {2'd1, 2'd0};
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.i_cfg_valid = 1'b0;
            got = obs();
            n_tot++;
            if (got !== pre[i])
                $display("FAIL mid_old[%0d]: got %b want %b", i, got, pre[i]);
            else n_pass++;
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            got = obs();
            exp = (i % 2 == 1) ? 6'b01_01_0_0 : 6'b00_10_1_0;
            n_tot++;
            if (got !== exp)
                $display("FAIL mid_new[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [5:0] got, exp;
        bus.i_cfg_valid = 1'b1;
        bus.i_period    = 2'd1;
        bus.i_offset    = {2'd3, 2'd0};
        tick();
        bus.i_cfg_valid = 1'b0;
        got = obs();
        n_tot++;
        if (got !== 6'b01_01_0_0)
            $display("FAIL oor_pre: got %b want %b", got, 6'b01_01_0_0);
        else n_pass++;
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b00_10_1_1)
            $display("FAIL oor_ack: got %b want %b", got, 6'b00_10_1_1);
        else n_pass++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            got = obs();
            exp = (i % 2 == 1) ? 6'b01_01_0_0 : 6'b00_00_1_0;
            n_tot++;
            if (got !== exp)
                $display("FAIL oor[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        logic [5:0] got;
        logic [5:0] seq [12] = '{
            6'b01_01_0_0, 6'b00_00_1_1, 6'b01_01_0_0, 6'b10_00_0_0,
            6'b10_00_0_0, 6'b10_00_0_0, 6'b10_00_0_0,
            6'b11_10_0_0, 6'b00_00_1_0, 6'b01_01_0_0,
            6'b01_00_0_0, 6'b00_00_0_1};
        bus.i_cfg_valid = 1'b1;
        bus.i_period    = 2'd3;
        bus.i_offset    = {2'd2, 2'd0};
        for (int i = 0; i < 12; i++) begin
            bus.i_enable    = !(i inside {[4:6], 10, 11});
            bus.i_cfg_valid = (i == 0) || (i == 10);
            if (i == 10) bus.i_offset = '0;
            tick();
            got = obs();
            n_tot++;
            if (got !== seq[i])
                $display("FAIL pause[%0d]: got %b want %b", i, got, seq[i]);
            else n_pass++;
        end
        bus.i_cfg_valid = 1'b0;
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b00_00_0_0)
            $display("FAIL pause_hold: got %b want %b", got, 6'b0);
        else n_pass++;
        bus.i_enable = 1'b1;
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b01_11_0_0)
            $display("FAIL pause_resume: got %b want %b", got, 6'b01_11_0_0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, exp;
        bus.i_cfg_valid = 1'b1;
        bus.i_period    = 2'd1;
        bus.i_offset    = '0;
        tick();
        bus.i_cfg_valid = 1'b0;
        got = obs();
        n_tot++;
        if (got !== 6'b10_00_0_0)
            $display("FAIL rstmid_pre: got %b want %b", got, 6'b10_00_0_0);
        else n_pass++;
        i_reset = 1'b1;
        tick();
        got = obs();
        n_tot++;
        if (got !== 6'b00_00_0_0)
            $display("FAIL rstmid_rst: got %b want %b", got, 6'b0);
        else n_pass++;
        i_reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            got = obs();
            exp = {2'(i % 4), (i % 4 == 1) ? 2'b11 : 2'b00,
                   (i % 4 == 0), 1'b0};
            n_tot++;
            if (got !== exp)
                $display("FAIL rstmid[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, exp;
        logic [5:0] pre [4] = '{6'b01_11_0_0, 6'b10_00_0_0,
                                6'b11_00_0_0, 6'b00_00_1_1};
        for (int i = 0; i < 4; i++) begin
            bus.i_cfg_valid = (i < 2);
            bus.i_period    = (i == 0) ? 2'd1 : 2'd2;
            bus.i_offset    = (i == 0) ? 4'b0000 : {2'd1, 2'd0};
            tick();
            got = obs();
            n_tot++;
            if (got !== pre[i])
                $display("FAIL b2b_pre[%0d]: got %b want %b", i, got, pre[i]);
            else n_pass++;
        end
        bus.i_cfg_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            got = obs();
            exp = (i % 3 == 1) ? 6'b01_01_0_0 :
                  (i % 3 == 2) ? 6'b10_10_0_0 : 6'b00_00_1_0;
            n_tot++;
            if (got !== exp)
                $display("FAIL b2b[%0d]: got %b want %b", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_offsets();
        test_mid_reload();
        test_out_of_range();
        test_pause();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
